mem_ctrl: RTL
=============

# mem_ctrl

Memory controller that sequences and arbitrates the CPU's single byte-wide RAM/IO port between instruction fetch and the MEM stage's loads and stores. It decomposes each request into byte accesses, reassembles little-endian read data with sign/zero extension, and stalls IO writes while the UART buffer is full. It sits between the IF/MEM pipeline stages and the external `mem_a`/`mem_din`/`mem_dout`/`mem_wr` port.

## Interface
- `IO_SEL`, default 2'b11: value of `addr[17:16]` that marks an address as IO.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `rdy`  in  1  global enable. Low freezes all state.
- `flush`  in  1  branch mispredict. Aborts an in-flight or pending fetch.
- `if_req`  in  1  fetch request, held until `if_ack` or `flush`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle pulse. `if_inst` is valid in that cycle.
- `if_inst`  out  32  fetched instruction, little-endian.
- `ls_req`  in  1  load/store request, held until `ls_ack`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  32  effective byte address.
- `ls_len`  in  3  access size: 1, 2 or 4. Any other value is treated as 4.
- `ls_signed`  in  1  sign-extend load data (lengths 1 and 2 only).
- `ls_wdata`  in  32  store data. Byte k goes to address+k.
- `ls_ack`  out  1  one-cycle pulse. `ls_rdata` is valid in that cycle for loads.
- `ls_rdata`  out  32  load result.
- `mem_a`  out  32  RAM/IO byte address (registered).
- `mem_dout`  out  8  write byte (registered).
- `mem_wr`  out  1  write strobe. Equals the internal write register AND `rdy`.
- `mem_din`  in  8  read byte. It holds the byte addressed by `mem_a` in the previous cycle.
- `io_buffer_full`  in  1  UART TX buffer full.

## Operation
- States:
  - IDLE, FETCH, LOAD, STORE.
  - Byte counter `cnt` is 3 bits.
  - Latched base address, length, signedness and write data.
- IDLE arbitration, evaluated at each edge:
  - `ls_req` wins over `if_req`.
  - `if_req` is ignored in any cycle where `flush`=1.
  - No request is accepted in a cycle where `if_ack` or `ls_ack` is high. This prevents re-accepting a still-held request.
- An in-flight FETCH is never preempted. A pending `ls_req` waits for it to finish.
- LOAD and FETCH, N bytes (FETCH has N=4):
  - The accept edge sets `mem_a`=base and `cnt`=0.
  - Each following edge increments `mem_a` while fewer than N addresses have been issued.
  - Each edge captures `mem_din` into byte `cnt` once data is valid.
  - After byte N-1 is captured: assemble the result, pulse the ack, go to IDLE.
- Load extension:
  - N=1 signed: bits 31:8 are copies of bit 7. N=1 unsigned: bits 31:8 are zero.
  - N=2: same rule, extending from bit 15.
  - N=4: no extension.
- STORE, N bytes:
  - The accept edge registers `mem_a`=base, `mem_dout`=wdata[7:0] and the write strobe=1.
  - Each later edge advances to the next byte.
  - The edge that retires the last byte clears the strobe, pulses `ls_ack` and returns to IDLE.
- IO stall:
  - Applies to a store whose address has `addr[17:16]`=`IO_SEL`.
  - If `io_buffer_full`=1 at the edge that would issue a byte, that edge registers the strobe=0 and holds `cnt` and `mem_a`.
  - The byte is retried each edge until `io_buffer_full`=0. Each IO byte is written exactly once.
- `flush`:
  - In FETCH: go to IDLE at the next edge, with no `if_ack` and data discarded.
  - In LOAD or STORE: no effect, because these are older than the branch.
- `rdy`=0:
  - State, counters, latches and all registered outputs hold.
  - `mem_wr` reads 0, so no duplicate writes occur.
- `rst` has priority over `rdy`.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0.
  - `mem_a`=0, `mem_dout`=0, `mem_wr`=0.
  - `if_ack`=0, `if_inst`=0, `ls_ack`=0, `ls_rdata`=0.
- Latencies, counted from the accept edge E0:
  - Load/fetch of N bytes: ack is high during cycle N+2 (E_{N+1} to E_{N+2}). LW and fetch take 5 cycles, LB takes 2 cycles.
  - Store of N bytes: `mem_wr` is high during cycles 1..N and `ls_ack` is high during cycle N+1. SW takes 4 cycles, plus one cycle per IO stall.
- Acks are exactly one cycle wide. The earliest next accept is the edge ending the ack cycle plus one.
- A `rst` pulse mid-transfer aborts it with no ack. A partially written word stays partially written.

## Test plan
- Reset and fetch:
  - Stimulus: `rst` high for 2 cycles, then `if_req`, `if_addr`=0x100, with RAM[0x100..0x103]=13 05 00 00.
  - Required: all outputs 0 during reset; `if_inst`=0x00000513; `if_ack` high for exactly 1 cycle, 5 cycles after accept.
- Loads, with RAM[0x200]=0x80 and RAM[0x201]=0x80:
  - LB → `ls_rdata`=0xFFFFFF80.
  - LBU → 0x00000080.
  - LH → 0xFFFF8080.
  - LHU → 0x00008080.
- Store:
  - Stimulus: SW 0xDEADBEEF to 0x1000.
  - Required: `mem_wr` high for 4 consecutive cycles with `mem_a` 0x1000..0x1003 and data EF, BE, AD, DE; `ls_ack` in the 5th cycle.
- Arbitration:
  - Stimulus: `if_req` and `ls_req` both high in IDLE.
  - Required: the load/store completes first. The fetch is accepted 1 cycle after `ls_ack`, and `ls_req` raised mid-fetch waits for `if_ack`.
- Flush:
  - Stimulus: `flush` in the 2nd FETCH cycle.
  - Required: no `if_ack` and IDLE next cycle. A new fetch at 0x40 then completes normally.
- IO and `rdy`:
  - Stimulus: SB 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles. Then `rdy` low for 2 cycles in the middle of an LW.
  - Required: one write of 0x41 after `io_buffer_full` drops. The LW result is correct and its ack is delayed by exactly 2 cycles.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// CPU-side request/ack buses plus the byte-wide RAM/IO port of the memory controller.
// The controller takes the slave modport; the pipeline/RAM environment takes master.
interface mem_ctrl_if;
    logic        rdy;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_inst;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_len;
    logic        ls_signed;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output rdy, flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_len,
               ls_signed, ls_wdata, mem_din, io_buffer_full,
        input  if_ack, if_inst, ls_ack, ls_rdata, mem_a, mem_dout, mem_wr
    );

    modport slave (
        input  rdy, flush, if_req, if_addr, ls_req, ls_we, ls_addr, ls_len,
               ls_signed, ls_wdata, mem_din, io_buffer_full,
        output if_ack, if_inst, ls_ack, ls_rdata, mem_a, mem_dout, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch vs load/store onto a single byte-wide RAM/IO port, splitting
// each request into byte accesses and reassembling little-endian read data.
module mem_ctrl #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_STORE} state_t;

    state_t      r_state, w_state;
    logic [2:0]  r_cnt, w_cnt, r_acnt, w_acnt, r_len, w_len;
    logic        r_dvld, w_dvld, r_signed, w_signed;
    logic [31:0] r_base, w_base, r_wdata, w_wdata, r_data, w_data;
    logic [31:0] r_mem_a, w_mem_a;
    logic [7:0]  r_dout, w_dout;
    logic        r_wr, w_wr, r_if_ack, w_if_ack, r_ls_ack, w_ls_ack;
    logic [31:0] r_if_inst, w_if_inst, r_ls_rdata, w_ls_rdata;
    logic [31:0] w_word, w_ext;
    logic [2:0]  w_len_req, w_idx;
    logic        w_io_stall;

    always_comb begin
        case (bus.ls_len)
            3'd1:    w_len_req = 3'd1;
            3'd2:    w_len_req = 3'd2;
            default: w_len_req = 3'd4;
        endcase
    end

    // mem_din carries the byte for index r_cnt once r_dvld is set
    always_comb begin
        w_word = r_data;
        w_word[{r_cnt[1:0], 3'b000} +: 8] = bus.mem_din;
        case (r_len)
            3'd1:    w_ext = r_signed ? {{24{w_word[7]}}, w_word[7:0]} : {24'b0, w_word[7:0]};
            3'd2:    w_ext = r_signed ? {{16{w_word[15]}}, w_word[15:0]} : {16'b0, w_word[15:0]};
            default: w_ext = w_word;
        endcase
    end

    assign w_io_stall = (r_base[17:16] == IO_SEL) && bus.io_buffer_full;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_acnt     = r_acnt;
        w_len      = r_len;
        w_dvld     = r_dvld;
        w_signed   = r_signed;
        w_base     = r_base;
        w_wdata    = r_wdata;
        w_data     = r_data;
        w_mem_a    = r_mem_a;
        w_dout     = r_dout;
        w_wr       = r_wr;
        w_if_ack   = 1'b0;
        w_ls_ack   = 1'b0;
        w_if_inst  = r_if_inst;
        w_ls_rdata = r_ls_rdata;
        w_idx      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (!r_if_ack && !r_ls_ack) begin
                    if (bus.ls_req) begin
                        w_base   = bus.ls_addr;
                        w_len    = w_len_req;
                        w_signed = bus.ls_signed;
                        w_wdata  = bus.ls_wdata;
                        w_cnt    = '0;
                        w_acnt   = 3'd1;
                        w_dvld   = 1'b0;
                        w_mem_a  = bus.ls_addr;
                        if (bus.ls_we) begin
                            w_state = S_STORE;
                            w_dout  = bus.ls_wdata[7:0];
                            w_wr    = !((bus.ls_addr[17:16] == IO_SEL) && bus.io_buffer_full);
                        end else begin
                            w_state = S_LOAD;
                        end
                    end else if (bus.if_req && !bus.flush) begin
                        w_state  = S_FETCH;
                        w_base   = bus.if_addr;
                        w_len    = 3'd4;
                        w_signed = 1'b0;
                        w_cnt    = '0;
                        w_acnt   = 3'd1;
                        w_dvld   = 1'b0;
                        w_mem_a  = bus.if_addr;
                    end
                end
            end
            S_FETCH, S_LOAD: begin
                if (r_state == S_FETCH && bus.flush) begin
                    w_state = S_IDLE;
                end else begin
                    if (r_acnt < r_len) begin
                        w_mem_a = r_mem_a + 32'd1;
                        w_acnt  = r_acnt + 3'd1;
                    end
                    w_dvld = 1'b1;
                    if (r_dvld) begin
                        w_data = w_word;
                        if (r_cnt == r_len - 3'd1) begin
                            w_state = S_IDLE;
                            if (r_state == S_FETCH) begin
                                w_if_ack  = 1'b1;
                                w_if_inst = w_word;
                            end else begin
                                w_ls_ack   = 1'b1;
                                w_ls_rdata = w_ext;
                            end
                        end else begin
                            w_cnt = r_cnt + 3'd1;
                        end
                    end
                end
            end
            S_STORE: begin
                if (r_wr && r_cnt == r_len - 3'd1) begin
                    w_wr     = 1'b0;
                    w_ls_ack = 1'b1;
                    w_state  = S_IDLE;
                end else begin
                    // r_wr low means byte r_cnt was stalled and is still owed
                    w_idx   = r_wr ? r_cnt + 3'd1 : r_cnt;
                    w_cnt   = w_idx;
                    w_mem_a = r_base + {29'b0, w_idx};
                    w_dout  = r_wdata[{w_idx[1:0], 3'b000} +: 8];
                    w_wr    = !w_io_stall;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acnt     <= '0;
            r_len      <= '0;
            r_dvld     <= 1'b0;
            r_signed   <= 1'b0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_mem_a    <= '0;
            r_dout     <= '0;
            r_wr       <= 1'b0;
            r_if_ack   <= 1'b0;
            r_ls_ack   <= 1'b0;
            r_if_inst  <= '0;
            r_ls_rdata <= '0;
        end else if (bus.rdy) begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_acnt     <= w_acnt;
            r_len      <= w_len;
            r_dvld     <= w_dvld;
            r_signed   <= w_signed;
            r_base     <= w_base;
            r_wdata    <= w_wdata;
            r_data     <= w_data;
            r_mem_a    <= w_mem_a;
            r_dout     <= w_dout;
            r_wr       <= w_wr;
            r_if_ack   <= w_if_ack;
            r_ls_ack   <= w_ls_ack;
            r_if_inst  <= w_if_inst;
            r_ls_rdata <= w_ls_rdata;
        end
    end

    assign bus.if_ack   = r_if_ack;
    assign bus.if_inst  = r_if_inst;
    assign bus.ls_ack   = r_ls_ack;
    assign bus.ls_rdata = r_ls_rdata;
    assign bus.mem_a    = r_mem_a;
    assign bus.mem_dout = r_dout;
    assign bus.mem_wr   = r_wr & bus.rdy;
endmodule
